mult16s_rr_scheduler: RTL and testbench
=======================================

Name: mult16s_rr_scheduler

Overview:
- Shares one 16x16 signed multiplier (instance of mult16s_normal_ripple) among NUM_REQ requesters.
- Per-requester valid/ready handshake; round-robin arbitration accepts at most one operation per cycle.
- Operands and product are registered around the multiplier. Each result returns with the ID of its requester.
- Sits between several datapath clients and the shared multiplier. Fully pipelined: one operation per cycle throughput.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, requester ID width, $clog2(NUM_REQ).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- hold  input  1  when 1, no grants are issued; in-flight operations still complete.
- req_valid  input  NUM_REQ  bit i: requester i presents an operation.
- req_ready  output  NUM_REQ  bit i: requester i is granted this cycle; at most one bit set.
- req_multiplicand  input  16*NUM_REQ  slice [16i+15:16i] is requester i multiplicand, signed.
- req_multiplier  input  16*NUM_REQ  slice [16i+15:16i] is requester i multiplier, signed.
- resp_valid  output  1  result valid; one-cycle pulse per operation.
- resp_id  output  ID_W  requester index of the result.
- resp_product  output  32  signed product.
- inflight  output  2  number of operations accepted but not yet returned (0..2).

Behaviour:
- Handshake: an operation is accepted from requester i in cycle k when req_valid[i] & req_ready[i].
- req_ready is combinational from req_valid, hold and the RR pointer. It is a one-hot grant, all zero when hold=1 or req_valid=0. A requester must not drop valid or change operands until accepted.
- Arbitration: the pointer holds the last granted index. The search starts at pointer+1 mod NUM_REQ and grants the first requester with valid set. The pointer updates to the granted index only on a grant; otherwise it holds.
- Reset value of the pointer is NUM_REQ-1, so requester 0 has top priority after reset.
- Stage 1 (end of cycle k): granted operands are latched into operand registers, and the tag {valid, id} into tag stage 1. If there is no grant, the tag valid is 0 and the operand registers hold their value.
- Stage 2 (end of cycle k+1): the multiplier output is latched into the product register, and tag stage 1 shifts to tag stage 2.
- Output: resp_valid, resp_id and resp_product are driven from stage 2 in cycle k+2. Fixed latency is 2 cycles from acceptance to response.
- There is no output backpressure; the consumer must accept every resp_valid pulse.
- Arithmetic: resp_product = signed(multiplicand) * signed(multiplier), full 32 bits, no truncation or saturation.
- Boundary values: -32768 * -32768 = 0x40000000; -32768 * 1 = 0xFFFF8000; 0x7FFF * 0x7FFF = 0x3FFF0001.
- inflight is the count of set tag-valid bits in stages 1 and 2.
- Simultaneous events: a new acceptance and a retiring response in the same cycle are both processed. Back-to-back grants are allowed every cycle with no bubbles.
- hold asserted mid-stream: no new grants; the two in-flight results still emerge on schedule.
- Reset (including mid-operation): tag valids clear, so in-flight operations are discarded with no response. The pointer is set to NUM_REQ-1.
- Reset values of outputs:
  - resp_valid = 0, resp_id = 0, resp_product = 0, inflight = 0.
  - req_ready = 0 during the reset cycle (gated by rst).
- Operand registers reset to 0.
- When tag valid is 0, resp_id and resp_product hold their last value. Only resp_valid qualifies them.

Decomposition:
- Package mult16s_sched_pkg holds the constants DATA_W=16, PROD_W=32, MULT_LATENCY=2, and the tag struct type {logic valid; logic [ID_W-1:0] id}.
- Sub-module rr_arbiter (parameter N; inputs clk, rst, req, advance; output one-hot gnt) contains the pointer and the priority search.
- The top level holds the operand mux, stage registers, tag shift register, inflight counter and the mult16s_normal_ripple instance.

Test Plan:
- Reset, then a single op from req 2 with 0x0003 * 0xFFFB: req_ready=0100 in the same cycle; two cycles later resp_valid=1, resp_id=2, resp_product=0xFFFFFFF1.
- All four valid continuously with distinct operands: grants in order 0,1,2,3,0,... one per cycle; responses are back-to-back with matching IDs and correct products.
- Boundary operands from req 1: -32768*-32768 gives 0x40000000; 0x7FFF*0x7FFF gives 0x3FFF0001; -32768*0x7FFF gives 0xC0008000.
- Fairness: req 0 and req 3 both valid, with last grant = 0: next grant goes to 3, then 0. A requester never waits more than NUM_REQ-1 grants.
- hold=1 for 3 cycles while req 1 is valid: req_ready=0 throughout; the two ops already in flight emerge with inflight stepping 2 -> 1 -> 0; the grant resumes on the cycle hold falls.
- rst pulsed with inflight=2: no resp_valid follows; resp_valid, resp_product and inflight are all 0. The next grant goes to requester 0 when all four are valid.

Source files
------------

// File: rtl/mult16s_sched_pkg.sv
// rtl/mult16s_sched_pkg.sv - shared constants, tag type and index helper for the multiplier scheduler
package mult16s_sched_pkg;

  localparam int DATA_W       = 16;
  localparam int PROD_W       = 32;
  localparam int MULT_LATENCY = 2;
  localparam int MAX_REQ      = 8;
  localparam int MAX_ID_W     = 3;

  // id is sized for the largest supported requester count; the top narrows it on output
  typedef struct packed {
    logic                valid;
    logic [MAX_ID_W-1:0] id;
  } tag_t;

  function automatic logic [MAX_ID_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [MAX_ID_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = idx | MAX_ID_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mult16s_normal_ripple.sv
// rtl/mult16s_normal_ripple.sv - combinational 16x16 signed multiplier, shift-add with ripple-carry adders
module mult16s_normal_ripple
  import mult16s_sched_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [PROD_W-1:0] p
);

  function automatic logic [PROD_W-1:0] ripple_add(input logic [PROD_W-1:0] x,
                                                   input logic [PROD_W-1:0] y,
                                                   input logic              cin);
    logic [PROD_W-1:0] s;
    logic              c;
    c = cin;
    for (int i = 0; i < PROD_W; i++) begin
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    return s;
  endfunction

  logic [PROD_W-1:0] a_ext;
  logic [PROD_W-1:0] acc;

  // multiplier MSB carries weight -2^15, so its partial product is subtracted
  always_comb begin
    a_ext = {{(PROD_W-DATA_W){a[DATA_W-1]}}, a};
    acc   = '0;
    for (int i = 0; i < DATA_W-1; i++) begin
      if (b[i]) acc = ripple_add(acc, a_ext << i, 1'b0);
    end
    if (b[DATA_W-1]) acc = ripple_add(acc, ~(a_ext << (DATA_W-1)), 1'b1);
  end

  assign p = acc;

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter, one-hot grant searched from the slot after the last winner
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int off = 1; off <= N; off++) begin
      idx = PW'((int'(ptr) + off) % N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  // reset to the last slot so requester 0 wins first
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= PW'(N-1);
    end else if (advance) begin
      for (int i = 0; i < N; i++) begin
        if (gnt[i]) ptr <= PW'(i);
      end
    end
  end

endmodule

// File: rtl/mult16s_rr_scheduler.sv
// rtl/mult16s_rr_scheduler.sv - shares one signed multiplier among requesters with a 2-cycle tagged pipeline
module mult16s_rr_scheduler
  import mult16s_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      hold,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [DATA_W*NUM_REQ-1:0] req_multiplicand,
  input  logic [DATA_W*NUM_REQ-1:0] req_multiplier,
  output logic                      resp_valid,
  output logic [ID_W-1:0]           resp_id,
  output logic [PROD_W-1:0]         resp_product,
  output logic [1:0]                inflight
);

  logic [NUM_REQ-1:0] arb_req;
  logic [NUM_REQ-1:0] gnt;
  logic [MAX_REQ-1:0] gnt_ext;
  logic               grant;
  logic [DATA_W-1:0]  sel_a, sel_b;
  logic [DATA_W-1:0]  op_a, op_b;
  logic [PROD_W-1:0]  mult_out;
  logic [PROD_W-1:0]  prod_q;
  tag_t               tag_q [MULT_LATENCY];

  // grants are suppressed during hold and in the reset cycle
  assign arb_req   = req_valid & {NUM_REQ{~hold & ~rst}};
  assign req_ready = gnt;
  assign grant     = |gnt;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (arb_req),
    .advance (grant),
    .gnt     (gnt)
  );

  always_comb begin
    gnt_ext              = '0;
    gnt_ext[NUM_REQ-1:0] = gnt;
    sel_a                = '0;
    sel_b                = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_a = sel_a | req_multiplicand[DATA_W*i +: DATA_W];
        sel_b = sel_b | req_multiplier[DATA_W*i +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_a     <= '0;
      op_b     <= '0;
      tag_q[0] <= '0;
    end else begin
      tag_q[0].valid <= grant;
      tag_q[0].id    <= onehot_to_idx(gnt_ext);
      if (grant) begin
        op_a <= sel_a;
        op_b <= sel_b;
      end
    end
  end

  mult16s_normal_ripple u_mult (
    .a (op_a),
    .b (op_b),
    .p (mult_out)
  );

  // id and product only advance with a valid tag so they hold between responses
  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q   <= '0;
      tag_q[1] <= '0;
    end else begin
      tag_q[1].valid <= tag_q[0].valid;
      if (tag_q[0].valid) begin
        tag_q[1].id <= tag_q[0].id;
        prod_q      <= mult_out;
      end
    end
  end

  assign resp_valid   = tag_q[1].valid;
  assign resp_id      = ID_W'(tag_q[1].id);
  assign resp_product = prod_q;
  assign inflight     = 2'(tag_q[0].valid) + 2'(tag_q[1].valid);

endmodule

// File: tb/tb_mult16s_rr_scheduler.sv
// tb/tb_mult16s_rr_scheduler.sv - directed self-checking bench for mult16s_rr_scheduler
module tb_mult16s_rr_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        hold;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [63:0] req_multiplicand;
  logic [63:0] req_multiplier;
  logic        resp_valid;
  logic [1:0]  resp_id;
  logic [31:0] resp_product;
  logic [1:0]  inflight;

  int checks = 0;
  int errors = 0;

  mult16s_rr_scheduler #(.NUM_REQ(4), .ID_W(2)) dut (
    .clk              (clk),
    .rst              (rst),
    .hold             (hold),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_multiplicand (req_multiplicand),
    .req_multiplier   (req_multiplier),
    .resp_valid       (resp_valid),
    .resp_id          (resp_id),
    .resp_product     (resp_product),
    .inflight         (inflight)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
    req_multiplicand[16*i +: 16] = a;
    req_multiplier[16*i +: 16]   = b;
  endtask

  task automatic test_reset();
    rst = 1'b1; hold = 1'b0; req_valid = 4'hF;
    req_multiplicand = '0; req_multiplier = '0;
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b exp 0000", req_ready); end
    tick();
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b exp 0", resp_valid); end
    checks++; if (resp_id !== 2'd0) begin errors++; $display("FAIL reset_resp_id got %0d exp 0", resp_id); end
    checks++; if (resp_product !== 32'h0) begin errors++; $display("FAIL reset_product got %h exp 0", resp_product); end
    checks++; if (inflight !== 2'd0) begin errors++; $display("FAIL reset_inflight got %0d exp 0", inflight); end
    req_valid = 4'h0; rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    set_op(2, 16'h0003, 16'hFFFB);
    req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready got %b exp 0100", req_ready); end
    tick();
    req_valid = 4'b0000;
    checks++; if (inflight !== 2'd1 || resp_valid !== 1'b0) begin errors++; $display("FAIL single_stage1 got inflight %0d valid %b exp 1 0", inflight, resp_valid); end
    tick();
    checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd2) begin errors++; $display("FAIL single_resp got valid %b id %0d exp 1 2", resp_valid, resp_id); end
    checks++; if (resp_product !== 32'hFFFFFFF1) begin errors++; $display("FAIL single_product got %h exp fffffff1", resp_product); end
    tick();
    checks++; if (resp_valid !== 1'b0 || resp_product !== 32'hFFFFFFF1) begin errors++; $display("FAIL single_hold_value got valid %b prod %h exp 0 fffffff1", resp_valid, resp_product); end
  endtask

  task automatic test_round_robin();
    logic [31:0] exp_p [4] = '{32'h00000023, 32'hFFFFFFEB, 32'hFFFFFDA8, 32'h00012340};
    logic [3:0]  exp_r;
    logic [1:0]  exp_f;
    rst = 1'b1; tick(); rst = 1'b0;
    set_op(0, 16'd5, 16'd7);
    set_op(1, 16'hFFF9, 16'd3);
    set_op(2, 16'h012C, 16'hFFFE);
    set_op(3, 16'h1234, 16'h0010);
    for (int c = 0; c < 10; c++) begin
      req_valid = (c < 8) ? 4'hF : 4'h0;
      #1;
      exp_r = (c < 8) ? (4'b0001 << (c % 4)) : 4'b0000;
      exp_f = (c == 0) ? 2'd0 : (c == 1 || c == 9) ? 2'd1 : 2'd2;
      checks++; if (req_ready !== exp_r) begin errors++; $display("FAIL rr_ready c%0d got %b exp %b", c, req_ready, exp_r); end
      checks++; if (inflight !== exp_f) begin errors++; $display("FAIL rr_inflight c%0d got %0d exp %0d", c, inflight, exp_f); end
      if (c >= 2) begin
        checks++;
        if (resp_valid !== 1'b1 || resp_id !== 2'((c-2) % 4) || resp_product !== exp_p[(c-2) % 4]) begin
          errors++; $display("FAIL rr_resp c%0d got v%b id%0d %h exp v1 id%0d %h", c, resp_valid, resp_id, resp_product, (c-2) % 4, exp_p[(c-2) % 4]);
        end
      end else begin
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rr_idle c%0d got %b exp 0", c, resp_valid); end
      end
      tick();
    end
  endtask

  task automatic test_boundary();
    logic [15:0] a [4]     = '{16'h8000, 16'h7FFF, 16'h8000, 16'h8000};
    logic [15:0] b [4]     = '{16'h8000, 16'h7FFF, 16'h7FFF, 16'h0001};
    logic [31:0] exp_p [4] = '{32'h40000000, 32'h3FFF0001, 32'hC0008000, 32'hFFFF8000};
    for (int c = 0; c < 6; c++) begin
      if (c < 4) begin
        set_op(1, a[c], b[c]);
        req_valid = 4'b0010;
      end else begin
        req_valid = 4'b0000;
      end
      #1;
      if (c < 4) begin
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bnd_ready c%0d got %b exp 0010", c, req_ready); end
      end
      if (c >= 2) begin
        checks++;
        if (resp_valid !== 1'b1 || resp_id !== 2'd1 || resp_product !== exp_p[c-2]) begin
          errors++; $display("FAIL bnd_resp c%0d got v%b id%0d %h exp v1 id1 %h", c, resp_valid, resp_id, resp_product, exp_p[c-2]);
        end
      end
      tick();
    end
  endtask

  task automatic test_fairness();
    logic [3:0] exp_r;
    req_valid = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL fair_first got %b exp 0001", req_ready); end
    tick();
    for (int c = 0; c < 4; c++) begin
      req_valid = 4'b1001;
      #1;
      exp_r = (c % 2 == 0) ? 4'b1000 : 4'b0001;
      checks++; if (req_ready !== exp_r) begin errors++; $display("FAIL fair_alt c%0d got %b exp %b", c, req_ready, exp_r); end
      tick();
    end
    req_valid = 4'b0000;
    repeat (3) tick();
  endtask

  task automatic test_hold();
    set_op(1, 16'd2, 16'd3);
    req_valid = 4'b0010; hold = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL hold_pre0 got %b exp 0010", req_ready); end
    tick();
    set_op(1, 16'hFFFC, 16'd5);
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL hold_pre1 got %b exp 0010", req_ready); end
    tick();
    set_op(1, 16'd7, 16'd7);
    hold = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0000 || inflight !== 2'd2) begin errors++; $display("FAIL hold_c2 got ready %b inflight %0d exp 0000 2", req_ready, inflight); end
    checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd1 || resp_product !== 32'd6) begin errors++; $display("FAIL hold_resp0 got v%b id%0d %h exp v1 id1 00000006", resp_valid, resp_id, resp_product); end
    tick();
    checks++; if (req_ready !== 4'b0000 || inflight !== 2'd1) begin errors++; $display("FAIL hold_c3 got ready %b inflight %0d exp 0000 1", req_ready, inflight); end
    checks++; if (resp_valid !== 1'b1 || resp_product !== 32'hFFFFFFEC) begin errors++; $display("FAIL hold_resp1 got v%b %h exp v1 ffffffec", resp_valid, resp_product); end
    tick();
    checks++; if (req_ready !== 4'b0000 || inflight !== 2'd0 || resp_valid !== 1'b0) begin errors++; $display("FAIL hold_c4 got ready %b inflight %0d v%b exp 0000 0 0", req_ready, inflight, resp_valid); end
    tick();
    hold = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL hold_resume got %b exp 0010", req_ready); end
    tick();
    req_valid = 4'b0000;
    tick();
    checks++; if (resp_valid !== 1'b1 || resp_product !== 32'h00000031) begin errors++; $display("FAIL hold_resp2 got v%b %h exp v1 00000031", resp_valid, resp_product); end
    tick();
  endtask

  task automatic test_reset_midflight();
    set_op(0, 16'd9, 16'hFFF7);
    set_op(1, 16'd1, 16'd1);
    set_op(2, 16'd2, 16'd2);
    set_op(3, 16'd3, 16'd3);
    req_valid = 4'hF;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL mrst_g0 got %b exp 0100", req_ready); end
    tick();
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL mrst_g1 got %b exp 1000", req_ready); end
    tick();
    checks++; if (inflight !== 2'd2) begin errors++; $display("FAIL mrst_inflight got %0d exp 2", inflight); end
    rst = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL mrst_ready_in_reset got %b exp 0000", req_ready); end
    tick();
    rst = 1'b0;
    checks++; if (resp_valid !== 1'b0 || resp_product !== 32'h0 || inflight !== 2'd0 || resp_id !== 2'd0) begin
      errors++; $display("FAIL mrst_cleared got v%b %h inflight %0d id %0d exp 0 0 0 0", resp_valid, resp_product, inflight, resp_id);
    end
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mrst_next_grant got %b exp 0001", req_ready); end
    tick();
    req_valid = 4'h0;
    checks++; if (resp_valid !== 1'b0 || inflight !== 2'd1) begin errors++; $display("FAIL mrst_no_stale got v%b inflight %0d exp 0 1", resp_valid, inflight); end
    tick();
    checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_product !== 32'hFFFFFFAF) begin
      errors++; $display("FAIL mrst_resp got v%b id%0d %h exp v1 id0 ffffffaf", resp_valid, resp_id, resp_product);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_boundary();
    test_fairness();
    test_hold();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
